// File: rtl/wb_byte_sequencer.sv
// Splits a 32-bit classic Wishbone access into one 8-bit slave access per selected byte lane.
// Lane order is big-endian: sel[3] is byte offset 0. Read bytes are gathered into a single 32-bit word.
module wb_byte_sequencer #(
    parameter int aw = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [aw-1:0] wbm_adr_i,
    input  logic [31:0]   wbm_dat_i,
    input  logic [3:0]    wbm_sel_i,
    input  logic          wbm_we_i,
    input  logic          wbm_cyc_i,
    input  logic          wbm_stb_i,
    input  logic [2:0]    wbm_cti_i,
    input  logic [1:0]    wbm_bte_i,
    output logic [31:0]   wbm_dat_o,
    output logic          wbm_ack_o,
    output logic          wbm_err_o,
    output logic          wbm_rty_o,
    output logic [aw-1:0] wbs_adr_o,
    output logic [7:0]    wbs_dat_o,
    output logic          wbs_we_o,
    output logic          wbs_cyc_o,
    output logic          wbs_stb_o,
    output logic [2:0]    wbs_cti_o,
    output logic [1:0]    wbs_bte_o,
    input  logic [7:0]    wbs_dat_i,
    input  logic          wbs_ack_i,
    input  logic          wbs_err_i,
    input  logic          wbs_rty_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_DONE,
        S_FAIL
    } state_t;

    state_t        r_state;
    logic [aw-3:0] r_adr;
    logic [31:0]   r_dat;
    logic          r_we;
    logic [3:0]    r_pend;
    logic [31:0]   r_rdat;
    logic          r_ack;
    logic          r_err;
    logic          r_rty;
    logic          r_cyc;

    logic [1:0]    w_off;
    logic [3:0]    w_lane;
    logic [3:0]    w_pend_rem;
    logic [7:0]    w_wbyte;
    logic [7:0]    w_dbyte [4];
    logic          w_unused;

    // Current lane is the highest pending select bit, i.e. the lowest byte offset.
    always_comb begin
        w_off = 2'd3;
        if (r_pend[3])
            w_off = 2'd0;
        else if (r_pend[2])
            w_off = 2'd1;
        else if (r_pend[1])
            w_off = 2'd2;
    end

    assign w_lane     = 4'b1000 >> w_off;
    assign w_pend_rem = r_pend & ~w_lane;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_dbyte[gi] = r_dat[8*(3-gi) +: 8];
        end
    endgenerate

    assign w_wbyte = w_dbyte[w_off];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_adr   <= '0;
            r_dat   <= '0;
            r_we    <= 1'b0;
            r_pend  <= '0;
            r_rdat  <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rty   <= 1'b0;
            r_cyc   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (wbm_cyc_i && wbm_stb_i) begin
                        r_adr  <= wbm_adr_i[aw-1:2];
                        r_dat  <= wbm_dat_i;
                        r_we   <= wbm_we_i;
                        r_pend <= wbm_sel_i;
                        r_rdat <= '0;
                        if (wbm_sel_i == 4'b0000) begin
                            r_ack   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cyc   <= 1'b1;
                            r_state <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    // A master abort wins over any slave response in the same cycle.
                    if (!wbm_cyc_i) begin
                        r_cyc   <= 1'b0;
                        r_pend  <= '0;
                        r_state <= S_IDLE;
                    end else if (wbs_err_i) begin
                        r_cyc   <= 1'b0;
                        r_pend  <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_FAIL;
                    end else if (wbs_rty_i) begin
                        r_cyc   <= 1'b0;
                        r_pend  <= '0;
                        r_rty   <= 1'b1;
                        r_state <= S_FAIL;
                    end else if (wbs_ack_i) begin
                        if (!r_we)
                            r_rdat[8*(3-w_off) +: 8] <= wbs_dat_i;
                        r_pend <= w_pend_rem;
                        if (w_pend_rem == 4'b0000) begin
                            r_cyc   <= 1'b0;
                            r_ack   <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_ack   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_err   <= 1'b0;
                    r_rty   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wbm_dat_o = r_rdat;
    assign wbm_ack_o = r_ack;
    assign wbm_err_o = r_err;
    assign wbm_rty_o = r_rty;

    assign wbs_adr_o = r_cyc ? {r_adr, w_off} : '0;
    assign wbs_dat_o = r_cyc ? w_wbyte : 8'h00;
    assign wbs_we_o  = r_cyc & r_we;
    assign wbs_cyc_o = r_cyc;
    assign wbs_stb_o = r_cyc;
    assign wbs_cti_o = 3'b000;
    assign wbs_bte_o = 2'b00;

    assign w_unused = ^{wbm_cti_i, wbm_bte_i, wbm_adr_i[1:0]};

endmodule

// File: tb/tb_wb_byte_sequencer.sv
// Scoreboard bench for wb_byte_sequencer: expected slave accesses and master responses are queued
// by the stimulus and popped by a slave model and a response monitor running alongside it.
module tb_wb_byte_sequencer;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] wbm_adr_i = '0;
    logic [31:0]   wbm_dat_i = '0;
    logic [3:0]    wbm_sel_i = '0;
    logic          wbm_we_i  = 1'b0;
    logic          wbm_cyc_i = 1'b0;
    logic          wbm_stb_i = 1'b0;
    logic [2:0]    wbm_cti_i = 3'b000;
    logic [1:0]    wbm_bte_i = 2'b00;
    logic [31:0]   wbm_dat_o;
    logic          wbm_ack_o;
    logic          wbm_err_o;
    logic          wbm_rty_o;
    logic [AW-1:0] wbs_adr_o;
    logic [7:0]    wbs_dat_o;
    logic          wbs_we_o;
    logic          wbs_cyc_o;
    logic          wbs_stb_o;
    logic [2:0]    wbs_cti_o;
    logic [1:0]    wbs_bte_o;
    logic [7:0]    wbs_dat_i = 8'h00;
    logic          wbs_ack_i = 1'b0;
    logic          wbs_err_i = 1'b0;
    logic          wbs_rty_i = 1'b0;

    wb_byte_sequencer #(.aw(AW)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbm_adr_i(wbm_adr_i),
        .wbm_dat_i(wbm_dat_i),
        .wbm_sel_i(wbm_sel_i),
        .wbm_we_i (wbm_we_i),
        .wbm_cyc_i(wbm_cyc_i),
        .wbm_stb_i(wbm_stb_i),
        .wbm_cti_i(wbm_cti_i),
        .wbm_bte_i(wbm_bte_i),
        .wbm_dat_o(wbm_dat_o),
        .wbm_ack_o(wbm_ack_o),
        .wbm_err_o(wbm_err_o),
        .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o),
        .wbs_dat_o(wbs_dat_o),
        .wbs_we_o (wbs_we_o),
        .wbs_cyc_o(wbs_cyc_o),
        .wbs_stb_o(wbs_stb_o),
        .wbs_cti_o(wbs_cti_o),
        .wbs_bte_o(wbs_bte_o),
        .wbs_dat_i(wbs_dat_i),
        .wbs_ack_i(wbs_ack_i),
        .wbs_err_i(wbs_err_i),
        .wbs_rty_i(wbs_rty_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [7:0]  dat;
        logic        we;
    } acc_t;

    typedef struct {
        int          kind;
        logic [31:0] dat;
        logic        chk_dat;
    } resp_t;

    acc_t       exp_acc[$];
    resp_t      exp_resp[$];
    logic [7:0] rd_q[$];

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;
    int slv_waits = 0;
    int slv_err_at = -1;
    int slv_rty_at = -1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic push_acc(input logic [31:0] adr, input logic [7:0] dat, input logic we);
        acc_t a;
        a.adr = adr;
        a.dat = dat;
        a.we  = we;
        exp_acc.push_back(a);
    endtask

    task automatic push_resp(input int kind, input logic [31:0] dat, input logic chk_dat);
        resp_t r;
        r.kind    = kind;
        r.dat     = dat;
        r.chk_dat = chk_dat;
        exp_resp.push_back(r);
    endtask

    // Slave model: answers after slv_waits wait cycles, checks each access against the scoreboard.
    task automatic slave_loop();
        int          wcnt = 0;
        bit          acked_last = 0;
        logic [31:0] hold_adr = '0;
        acc_t        e;
        forever begin
            @(negedge clk);
            wbs_ack_i = 1'b0;
            wbs_err_i = 1'b0;
            wbs_rty_i = 1'b0;
            if (wbs_cyc_o && wbs_stb_o && !rst) begin
                if (acked_last) begin
                    wcnt = 0;
                    acked_last = 0;
                end
                if (wcnt == 0)
                    hold_adr = wbs_adr_o;
                else
                    check("adr_stable_in_wait", wbs_adr_o, hold_adr);
                if (wcnt >= slv_waits) begin
                    if (exp_acc.size() == 0) begin
                        check("unexpected_slave_access", wbs_adr_o, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_acc.pop_front();
                        check("slave_adr", wbs_adr_o, e.adr);
                        check("slave_we", wbs_we_o, e.we);
                        if (e.we)
                            check("slave_wdat", wbs_dat_o, e.dat);
                    end
                    if (acc_cnt == slv_err_at)
                        wbs_err_i = 1'b1;
                    else if (acc_cnt == slv_rty_at)
                        wbs_rty_i = 1'b1;
                    else begin
                        wbs_ack_i = 1'b1;
                        wbs_dat_i = (rd_q.size() != 0) ? rd_q.pop_front() : 8'hEE;
                    end
                    acc_cnt++;
                    acked_last = 1;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                acked_last = 0;
            end
        end
    endtask

    task automatic resp_loop();
        resp_t r;
        int    kind;
        forever begin
            @(negedge clk);
            if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
                check("resp_onehot", 64'(wbm_ack_o + wbm_err_o + wbm_rty_o), 64'd1);
                kind = wbm_err_o ? 1 : (wbm_rty_o ? 2 : 0);
                if (exp_resp.size() == 0) begin
                    check("unexpected_master_resp", 64'(kind), 64'hFF);
                end else begin
                    r = exp_resp.pop_front();
                    check("resp_kind", 64'(kind), 64'(r.kind));
                    if (r.chk_dat)
                        check("resp_rdat", wbm_dat_o, r.dat);
                end
            end
        end
    endtask

    task automatic raise_req(input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic we);
        @(negedge clk);
        #2;
        wbm_adr_i = adr;
        wbm_dat_i = dat;
        wbm_sel_i = sel;
        wbm_we_i  = we;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
    endtask

    // Full master access; stb is held through the response cycle so a restart would be visible.
    task automatic do_req(input string name, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic we, input int exp_lat,
                          input logic [31:0] exp_hold);
        int cnt = 0;
        raise_req(adr, dat, sel, we);
        forever begin
            @(negedge clk);
            #2;
            cnt++;
            if (wbm_ack_o || wbm_err_o || wbm_rty_o || cnt > 200)
                break;
        end
        check({name, "_latency"}, 64'(cnt), 64'(exp_lat));
        @(negedge clk);
        #2;
        check({name, "_resp_one_cycle"}, {wbm_ack_o, wbm_err_o, wbm_rty_o}, 3'b000);
        check({name, "_dat_hold"}, wbm_dat_o, exp_hold);
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check({name, "_queues_empty"}, 64'(exp_acc.size() + exp_resp.size()), 64'd0);
    endtask

    initial begin
        int base;
        int cnt;
        fork
            slave_loop();
            resp_loop();
        join_none

        #1;
        check("reset_wbm", {wbm_ack_o, wbm_err_o, wbm_rty_o, wbm_dat_o}, '0);
        check("reset_wbs_ctl", {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_cti_o, wbs_bte_o}, '0);
        check("reset_wbs_bus", {wbs_adr_o, wbs_dat_o}, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single-lane read.
        push_acc(32'h101, 8'h00, 1'b0);
        rd_q.push_back(8'hA5);
        push_resp(0, 32'h00A5_0000, 1'b1);
        do_req("rd_sel0100", 32'h100, 32'h0, 4'b0100, 1'b0, 2, 32'h00A5_0000);

        // Four-lane write.
        push_acc(32'h200, 8'h11, 1'b1);
        push_acc(32'h201, 8'h22, 1'b1);
        push_acc(32'h202, 8'h33, 1'b1);
        push_acc(32'h203, 8'h44, 1'b1);
        push_resp(0, 32'h0, 1'b0);
        do_req("wr_sel1111", 32'h200, 32'h1122_3344, 4'b1111, 1'b1, 5, 32'h0);

        // Read with two wait states per byte.
        slv_waits = 2;
        push_acc(32'h302, 8'h00, 1'b0);
        push_acc(32'h303, 8'h00, 1'b0);
        rd_q.push_back(8'h5A);
        rd_q.push_back(8'hC3);
        push_resp(0, 32'h0000_5AC3, 1'b1);
        do_req("rd_waits", 32'h300, 32'h0, 4'b0011, 1'b0, 7, 32'h0000_5AC3);
        slv_waits = 0;

        // Empty select: immediate ack, data word cleared.
        push_resp(0, 32'h0, 1'b1);
        do_req("rd_sel0000", 32'h340, 32'h0, 4'b0000, 1'b0, 1, 32'h0);

        // Slave error on the second byte.
        slv_err_at = acc_cnt + 1;
        push_acc(32'h400, 8'hDE, 1'b1);
        push_acc(32'h401, 8'hAD, 1'b1);
        push_resp(1, 32'h0, 1'b0);
        do_req("wr_err", 32'h400, 32'hDEAD_BEEF, 4'b1111, 1'b1, 3, 32'h0);
        slv_err_at = -1;

        // Slave retry on the only byte.
        slv_rty_at = acc_cnt;
        push_acc(32'h502, 8'hCC, 1'b1);
        push_resp(2, 32'h0, 1'b0);
        do_req("wr_rty", 32'h500, 32'h0000_CC00, 4'b0010, 1'b1, 2, 32'h0);
        slv_rty_at = -1;

        // Master abort while the slave acks byte 2: that ack must be ignored.
        base = acc_cnt;
        push_acc(32'h600, 8'h00, 1'b0);
        push_acc(32'h601, 8'h00, 1'b0);
        rd_q.push_back(8'h01);
        rd_q.push_back(8'h02);
        raise_req(32'h600, 32'h0, 4'b1111, 1'b0);
        cnt = 0;
        while (acc_cnt < base + 2 && cnt < 50) begin
            @(negedge clk);
            #2;
            cnt++;
        end
        check("abort_reached_byte2", 64'(acc_cnt - base), 64'd2);
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        @(negedge clk);
        #2;
        check("abort_cyc_drop", {wbs_cyc_o, wbs_stb_o}, 2'b00);
        repeat (3) @(negedge clk);
        #2;
        check("abort_queues_empty", 64'(exp_acc.size() + exp_resp.size()), 64'd0);

        // Asynchronous reset in the middle of a waited slave access.
        slv_waits = 3;
        raise_req(32'h700, 32'hCAFE_F00D, 4'b1111, 1'b1);
        repeat (2) @(negedge clk);
        #2;
        check("rst_mid_bus_stb_high", wbs_stb_o, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid_bus_cyc_drop", {wbs_cyc_o, wbs_stb_o, wbs_we_o}, 3'b000);
        check("rst_mid_bus_wbm", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 3'b000);
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        slv_waits = 0;
        repeat (2) @(negedge clk);

        // Normal access after reset.
        push_acc(32'h800, 8'h00, 1'b0);
        push_acc(32'h803, 8'h00, 1'b0);
        rd_q.push_back(8'h12);
        rd_q.push_back(8'h34);
        push_resp(0, 32'h1200_0034, 1'b1);
        do_req("rd_after_rst", 32'h800, 32'h0, 4'b1001, 1'b0, 3, 32'h1200_0034);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
